vga_timing: RTL and testbench
=============================

// Module: vga_timing
// PURPOSE
//  Upstream raster generator for the pong display pipeline. Produces hsync/vsync and the active-area
//  pixel coordinate (row, col) that paddle/ball/score object detectors consume, and pulses frame_tick
//  once per frame so game-state blocks (paddle and ball movement) update only during vertical blanking.
//  All outputs are registered and mutually aligned: row, col, active, hsync, vsync describe the same pixel.
// PARAMETERS
//  CLKS_PER_PIXEL  2    clk cycles per pixel (50 MHz clk -> 25 MHz pixel rate); must be >= 1
//  ACTIVE_COLS     640  visible pixels per line
//  H_FRONT         16   horizontal front porch, pixels
//  H_SYNC          96   horizontal sync width, pixels
//  H_BACK          48   horizontal back porch, pixels
//  ACTIVE_ROWS     480  visible lines per frame
//  V_FRONT         10   vertical front porch, lines
//  V_SYNC          2    vertical sync width, lines
//  V_BACK          33   vertical back porch, lines
//  SYNC_ACTIVE     0    asserted sync level (0 = negative polarity, VGA 640x480 standard)
// PORTS
//  clk         in   1                      system clock
//  rst_n       in   1                      synchronous reset, active low
//  pixel_tick  out  1                      1-clk strobe: the pixel below is new this cycle
//  col         out  $clog2(ACTIVE_COLS)    active column 0..ACTIVE_COLS-1; 0 outside active area
//  row         out  $clog2(ACTIVE_ROWS)    active row 0..ACTIVE_ROWS-1; 0 outside active area
//  active      out  1                      1 when (row, col) is a visible pixel
//  hsync       out  1                      horizontal sync, level per SYNC_ACTIVE
//  vsync       out  1                      vertical sync, level per SYNC_ACTIVE
//  frame_tick  out  1                      1-clk strobe on the first clk of the first V_FRONT line
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active low (rst_n). No other clock or reset.
//  - Reset (rst_n=0 sampled at posedge): prescaler=0, h_cnt=0, v_cnt=0; outputs: pixel_tick=0, col=0, row=0,
//    active=1 (pixel 0,0), hsync=vsync=!SYNC_ACTIVE, frame_tick=0. Deasserting reset mid-frame restarts at 0,0.
//  - Prescaler counts 0..CLKS_PER_PIXEL-1 and wraps; advance occurs in the clk where it equals CLKS_PER_PIXEL-1.
//    pixel_tick is registered and is high in the clk after each advance. With CLKS_PER_PIXEL=1 it is constantly 1
//    after the first clk out of reset.
//  - h_cnt spans 0..H_TOTAL-1, where H_TOTAL = ACTIVE_COLS+H_FRONT+H_SYNC+H_BACK (800). On advance it increments.
//    When it wraps to 0, v_cnt increments; v_cnt spans 0..V_TOTAL-1, where V_TOTAL = 525, then wraps to 0.
//  - Each axis is a 4-state FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. Transitions occur when the
//    axis count reaches the segment boundary. The horizontal FSM steps on pixel advance; the vertical FSM
//    steps on line wrap. State is derived registered, never decoded combinationally on outputs.
//  - active = (h_state==ACTIVE) && (v_state==ACTIVE); col=h_cnt and row=v_cnt while in the axis ACTIVE state,
//    else forced 0. Width: the counters are wide enough for H_TOTAL/V_TOTAL; the outputs are truncated only
//    when in range.
//  - hsync = SYNC_ACTIVE iff h_state==SYNC; vsync = SYNC_ACTIVE iff v_state==SYNC. All timing is aligned to
//    the same registered pixel as row/col (0 clk skew between outputs).
//  - Latency: outputs change one clk after the advance that produced them; they are held constant between
//    advances.
//  - frame_tick: asserted for exactly one clk when v_cnt becomes ACTIVE_ROWS (h_cnt=0), coincident with
//    the pixel_tick of that pixel.
//  - Simultaneous h wrap and v wrap (last pixel of frame): both counters go to 0 on the same advance; the
//    next pixel is (0,0) active.
//  - Parameter sanity: elaboration error if any porch/sync is 0 or CLKS_PER_PIXEL < 1.
// STRUCTURE
//  - pong_pkg: typedef enum logic [1:0] {SEG_ACTIVE, SEG_FRONT, SEG_SYNC, SEG_BACK} seg_t; VGA 640x480
//    default timing localparams shared with paddle/ball/renderer (ACTIVE_ROWS, ACTIVE_COLS).
//  - One sub-module, vga_axis: a counter plus seg_t FSM, parameterised by ACTIVE/FRONT/SYNC/BACK, with inputs
//    step and outputs cnt, seg, wrap. It is instantiated twice (h: step=advance; v: step=h wrap).
//  - The top level owns the prescaler, output registers and frame_tick.
// TESTING
//  1. Hold rst_n=0 5 clks -> row=0, col=0, active=1, hsync=vsync=1, frame_tick=0, pixel_tick=0.
//  2. Free-run one line, CLKS_PER_PIXEL=2 -> active for 640 pixels (1280 clks); hsync low pixels 656..751;
//     the line period is 1600 clks.
//  3. Run 2 full frames -> frame_tick period 840000 clks; vsync low on lines 490-491 only;
//     active count 307200 per frame.
//  4. Check the last pixel (h=799, v=524) -> the next pixel is row=0, col=0, active=1, and there is no
//     extra frame_tick.
//  5. Assert rst_n=0 for 1 clk at line 300, col 400 -> the next clk shows the reset values; counting
//     resumes from (0,0).
//  6. Use CLKS_PER_PIXEL=1 with small params (8/2/2/2 and 4/1/1/1) -> pixel_tick is stuck at 1; the
//     line period is 14 clks and the frame period is 98 clks.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong display pipeline: raster segment encoding and the
// default VGA 640x480@60 timing used by the raster, paddle, ball and renderer blocks.
package pong_pkg;

  typedef enum logic [1:0] {
    SEG_ACTIVE,
    SEG_FRONT,
    SEG_SYNC,
    SEG_BACK
  } seg_t;

  localparam int VGA_CLKS_PER_PIXEL = 2;
  localparam int VGA_ACTIVE_COLS    = 640;
  localparam int VGA_H_FRONT        = 16;
  localparam int VGA_H_SYNC         = 96;
  localparam int VGA_H_BACK         = 48;
  localparam int VGA_ACTIVE_ROWS    = 480;
  localparam int VGA_V_FRONT        = 10;
  localparam int VGA_V_SYNC         = 2;
  localparam int VGA_V_BACK         = 33;
  localparam int VGA_SYNC_ACTIVE    = 0;

  // Bit width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_axis.sv
// One raster axis: a wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK segment FSM.
// cnt/seg present the values the axis takes at the coming edge, so the parent can register aligned outputs.
module vga_axis
  import pong_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FRONT  = 16,
  parameter int SYNC   = 96,
  parameter int BACK   = 48,
  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK,
  localparam int CW    = cnt_width(TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output seg_t          seg,
  output logic          wrap
);

  if (ACTIVE < 2 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_params
    $error("vga_axis: ACTIVE must be >= 2 and every porch/sync width >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  seg_t          seg_q, seg_d;

  always_comb begin
    wrap  = step && (cnt_q == CW'(TOTAL - 1));
    cnt_d = cnt_q;
    seg_d = seg_q;
    if (step) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      // Segment changes exactly on the counts where a new segment begins.
      if (cnt_d == '0)                               seg_d = SEG_ACTIVE;
      else if (cnt_d == CW'(ACTIVE))                 seg_d = SEG_FRONT;
      else if (cnt_d == CW'(ACTIVE + FRONT))         seg_d = SEG_SYNC;
      else if (cnt_d == CW'(ACTIVE + FRONT + SYNC))  seg_d = SEG_BACK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      seg_q <= SEG_ACTIVE;
    end else begin
      cnt_q <= cnt_d;
      seg_q <= seg_d;
    end
  end

  assign cnt = cnt_d;
  assign seg = seg_d;

endmodule

// File: rtl/vga_timing.sv
// Raster generator: pixel prescaler, horizontal and vertical axes, and a bank of output
// registers so row/col/active/hsync/vsync/pixel_tick/frame_tick all describe the same pixel.
module vga_timing
  import pong_pkg::*;
#(
  parameter int CLKS_PER_PIXEL = VGA_CLKS_PER_PIXEL,
  parameter int ACTIVE_COLS    = VGA_ACTIVE_COLS,
  parameter int H_FRONT        = VGA_H_FRONT,
  parameter int H_SYNC         = VGA_H_SYNC,
  parameter int H_BACK         = VGA_H_BACK,
  parameter int ACTIVE_ROWS    = VGA_ACTIVE_ROWS,
  parameter int V_FRONT        = VGA_V_FRONT,
  parameter int V_SYNC         = VGA_V_SYNC,
  parameter int V_BACK         = VGA_V_BACK,
  parameter int SYNC_ACTIVE    = VGA_SYNC_ACTIVE,
  localparam int COL_W         = $clog2(ACTIVE_COLS),
  localparam int ROW_W         = $clog2(ACTIVE_ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pixel_tick,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_tick
);

  localparam int   H_TOTAL  = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK;
  localparam int   V_TOTAL  = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
  localparam int   HW       = cnt_width(H_TOTAL);
  localparam int   VW       = cnt_width(V_TOTAL);
  localparam int   PW       = cnt_width(CLKS_PER_PIXEL);
  localparam logic SYNC_LVL = (SYNC_ACTIVE != 0);

  if (CLKS_PER_PIXEL < 1) begin : g_bad_params
    $error("vga_timing: CLKS_PER_PIXEL must be >= 1");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic          advance;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  seg_t          h_seg, v_seg;
  logic          h_wrap, v_wrap;

  logic             pixel_tick_q, pixel_tick_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             active_q, active_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_tick_q, frame_tick_d;

  always_comb begin
    advance = (presc_q == PW'(CLKS_PER_PIXEL - 1));
    presc_d = advance ? '0 : presc_q + PW'(1);
  end

  vga_axis #(
    .ACTIVE (ACTIVE_COLS),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (advance),
    .cnt   (h_cnt),
    .seg   (h_seg),
    .wrap  (h_wrap)
  );

  vga_axis #(
    .ACTIVE (ACTIVE_ROWS),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (h_wrap),
    .cnt   (v_cnt),
    .seg   (v_seg),
    .wrap  (v_wrap)
  );

  // Output registers load from the axes' upcoming state, landing in the same edge as the counters.
  always_comb begin
    pixel_tick_d = advance;
    col_d        = (h_seg == SEG_ACTIVE) ? COL_W'(h_cnt) : '0;
    row_d        = (v_seg == SEG_ACTIVE) ? ROW_W'(v_cnt) : '0;
    active_d     = (h_seg == SEG_ACTIVE) && (v_seg == SEG_ACTIVE);
    hsync_d      = (h_seg == SEG_SYNC) ? SYNC_LVL : !SYNC_LVL;
    vsync_d      = (v_seg == SEG_SYNC) ? SYNC_LVL : !SYNC_LVL;
    frame_tick_d = h_wrap && !v_wrap && (v_cnt == VW'(ACTIVE_ROWS));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      pixel_tick_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      active_q     <= 1'b1;
      hsync_q      <= !SYNC_LVL;
      vsync_q      <= !SYNC_LVL;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pixel_tick_q <= pixel_tick_d;
      col_q        <= col_d;
      row_q        <= row_d;
      active_q     <= active_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pixel_tick = pixel_tick_q;
  assign col        = col_q;
  assign row        = row_q;
  assign active     = active_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three small-raster instances checked every clk against a pixel-index model,
// plus a vector table, a mid-frame reset sequence and per-frame period/active/sync measurements.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // A: 2 clk/pixel, 8/2/2/2 x 4/1/1/1, negative sync
  logic       a_pt, a_act, a_hs, a_vs, a_ft;
  logic [2:0] a_col;
  logic [1:0] a_row;
  // B: 1 clk/pixel, same raster
  logic       b_pt, b_act, b_hs, b_vs, b_ft;
  logic [2:0] b_col;
  logic [1:0] b_row;
  // C: 3 clk/pixel, 5/1/2/1 x 3/2/1/1, positive sync
  logic       c_pt, c_act, c_hs, c_vs, c_ft;
  logic [2:0] c_col;
  logic [1:0] c_row;

  vga_timing #(.CLKS_PER_PIXEL(2), .ACTIVE_COLS(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
               .ACTIVE_ROWS(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .pixel_tick(a_pt), .col(a_col), .row(a_row),
    .active(a_act), .hsync(a_hs), .vsync(a_vs), .frame_tick(a_ft));

  vga_timing #(.CLKS_PER_PIXEL(1), .ACTIVE_COLS(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
               .ACTIVE_ROWS(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .pixel_tick(b_pt), .col(b_col), .row(b_row),
    .active(b_act), .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft));

  vga_timing #(.CLKS_PER_PIXEL(3), .ACTIVE_COLS(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
               .ACTIVE_ROWS(3), .V_FRONT(2), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .pixel_tick(c_pt), .col(c_col), .row(c_row),
    .active(c_act), .hsync(c_hs), .vsync(c_vs), .frame_tick(c_ft));

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    else n_pass++;
  endtask

  typedef struct {
    logic       pt;
    logic [7:0] col;
    logic [7:0] row;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  // Expected outputs after n clocks out of reset, from the pixel index alone.
  function automatic exp_t model(input int cpp, input int ac, input int hf, input int hs, input int hb,
                                 input int ar, input int vf, input int vs, input int vb,
                                 input logic sa, input int unsigned n);
    exp_t e;
    int ht, vt, p, h, v;
    ht = ac + hf + hs + hb;
    vt = ar + vf + vs + vb;
    p  = int'((n / cpp) % (ht * vt));
    h  = p % ht;
    v  = p / ht;
    e.pt  = (n > 0) && (n % cpp == 0);
    e.act = (h < ac) && (v < ar);
    e.col = (h < ac) ? 8'(h) : 8'd0;
    e.row = (v < ar) ? 8'(v) : 8'd0;
    e.hs  = (h >= ac + hf && h < ac + hf + hs) ? sa : !sa;
    e.vs  = (v >= ar + vf && v < ar + vf + vs) ? sa : !sa;
    e.ft  = e.pt && (h == 0) && (v == ar);
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic pt, input logic [7:0] col,
                     input logic [7:0] row, input logic act, input logic hs, input logic vs, input logic ft);
    check({tag, ".pixel_tick"}, 32'(pt), 32'(e.pt));
    check({tag, ".col"}, 32'(col), 32'(e.col));
    check({tag, ".row"}, 32'(row), 32'(e.row));
    check({tag, ".active"}, 32'(act), 32'(e.act));
    check({tag, ".hsync"}, 32'(hs), 32'(e.hs));
    check({tag, ".vsync"}, 32'(vs), 32'(e.vs));
    check({tag, ".frame_tick"}, 32'(ft), 32'(e.ft));
  endtask

  // Clocks since the last edge that sampled reset; rst_n only changes 1 time unit after posedge.
  int unsigned n_clk = 0;
  bit chk_en = 1'b0;
  always @(posedge clk) n_clk <= rst_n ? n_clk + 1 : 0;

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("A", model(2, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, n_clk), a_pt, 8'(a_col), 8'(a_row), a_act, a_hs, a_vs, a_ft);
      cmp("B", model(1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, n_clk), b_pt, 8'(b_col), 8'(b_row), b_act, b_hs, b_vs, b_ft);
      cmp("C", model(3, 5, 1, 2, 1, 3, 2, 1, 1, 1'b1, n_clk), c_pt, 8'(c_col), 8'(c_row), c_act, c_hs, c_vs, c_ft);
    end
  end

  logic ft_w[3], pt_w[3], act_w[3], vs_w[3], hs_w[3];
  always_comb begin
    ft_w[0] = a_ft;  pt_w[0] = a_pt;  act_w[0] = a_act; vs_w[0] = a_vs; hs_w[0] = a_hs;
    ft_w[1] = b_ft;  pt_w[1] = b_pt;  act_w[1] = b_act; vs_w[1] = b_vs; hs_w[1] = b_hs;
    ft_w[2] = c_ft;  pt_w[2] = c_pt;  act_w[2] = c_act; vs_w[2] = c_vs; hs_w[2] = c_hs;
  end

  // One frame of instance idx between successive frame_ticks: clk period, active/vsync/hsync pixels.
  task automatic measure(input string tag, input int idx, input int exp_period, input int exp_act,
                         input int exp_vsync, input int exp_hsync, input logic sync_lvl);
    bit got;
    int period, nact, nvs, nhs;
    got = 1'b0;
    for (int i = 0; i < exp_period + 20 && !got; i++) begin
      @(negedge clk);
      if (ft_w[idx]) got = 1'b1;
    end
    check({tag, ".first_frame_tick_seen"}, 32'(got), 32'd1);
    if (got) begin
      got = 1'b0; period = 0; nact = 0; nvs = 0; nhs = 0;
      for (int i = 0; i < 2 * exp_period + 20 && !got; i++) begin
        @(negedge clk);
        period++;
        if (pt_w[idx] && act_w[idx]) nact++;
        if (pt_w[idx] && vs_w[idx] == sync_lvl) nvs++;
        if (pt_w[idx] && hs_w[idx] == sync_lvl) nhs++;
        if (ft_w[idx]) got = 1'b1;
      end
      check({tag, ".second_frame_tick_seen"}, 32'(got), 32'd1);
      check({tag, ".frame_period_clks"}, 32'(period), 32'(exp_period));
      check({tag, ".active_pixels_per_frame"}, 32'(nact), 32'(exp_act));
      check({tag, ".vsync_pixels_per_frame"}, 32'(nvs), 32'(exp_vsync));
      check({tag, ".hsync_pixels_per_frame"}, 32'(nhs), 32'(exp_hsync));
    end
  endtask

  typedef struct {
    int         n;
    logic [7:0] col;
    logic [7:0] row;
    logic       act;
    logic       hs;
    logic       vs;
    logic       pt;
    logic       ft;
  } vec_t;

  vec_t tbl[18];

  initial begin : main
    int cur;
    // Instance A outputs after n clocks out of reset (pixel = n/2, 14 pixels/line, 7 lines/frame).
    tbl[0]  = '{0,   0, 0, 1, 1, 1, 0, 0};
    tbl[1]  = '{1,   0, 0, 1, 1, 1, 0, 0};
    tbl[2]  = '{2,   1, 0, 1, 1, 1, 1, 0};
    tbl[3]  = '{3,   1, 0, 1, 1, 1, 0, 0};
    tbl[4]  = '{16,  0, 0, 0, 1, 1, 1, 0};
    tbl[5]  = '{20,  0, 0, 0, 0, 1, 1, 0};
    tbl[6]  = '{22,  0, 0, 0, 0, 1, 1, 0};
    tbl[7]  = '{24,  0, 0, 0, 1, 1, 1, 0};
    tbl[8]  = '{28,  0, 1, 1, 1, 1, 1, 0};
    tbl[9]  = '{30,  1, 1, 1, 1, 1, 1, 0};
    tbl[10] = '{112, 0, 0, 0, 1, 1, 1, 1};
    tbl[11] = '{113, 0, 0, 0, 1, 1, 0, 0};
    tbl[12] = '{140, 0, 0, 0, 1, 0, 1, 0};
    tbl[13] = '{168, 0, 0, 0, 1, 1, 1, 0};
    tbl[14] = '{194, 0, 0, 0, 1, 1, 1, 0};
    tbl[15] = '{196, 0, 0, 1, 1, 1, 1, 0};
    tbl[16] = '{198, 1, 0, 1, 1, 1, 1, 0};
    tbl[17] = '{308, 0, 0, 0, 1, 1, 1, 1};

    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_en = 1'b1;
    cur = 0;
    foreach (tbl[i]) begin
      while (cur < tbl[i].n) begin
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cur++;
      end
      check($sformatf("vec%0d.col", i), 32'(a_col), 32'(tbl[i].col));
      check($sformatf("vec%0d.row", i), 32'(a_row), 32'(tbl[i].row));
      check($sformatf("vec%0d.active", i), 32'(a_act), 32'(tbl[i].act));
      check($sformatf("vec%0d.hsync", i), 32'(a_hs), 32'(tbl[i].hs));
      check($sformatf("vec%0d.vsync", i), 32'(a_vs), 32'(tbl[i].vs));
      check($sformatf("vec%0d.pixel_tick", i), 32'(a_pt), 32'(tbl[i].pt));
      check($sformatf("vec%0d.frame_tick", i), 32'(a_ft), 32'(tbl[i].ft));
    end

    // Mid-frame single-clk reset, then restart from pixel (0,0).
    repeat (45) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst.A.col", 32'(a_col), 32'd0);
    check("midrst.A.row", 32'(a_row), 32'd0);
    check("midrst.A.active", 32'(a_act), 32'd1);
    check("midrst.A.pixel_tick", 32'(a_pt), 32'd0);
    check("midrst.B.hsync", 32'(b_hs), 32'd1);
    check("midrst.C.vsync", 32'(c_vs), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst.A.col_after", 32'(a_col), 32'd1);
    check("midrst.A.pixel_tick_after", 32'(a_pt), 32'd1);
    check("midrst.B.col_after", 32'(b_col), 32'd2);

    measure("A", 0, 196, 32, 14, 14, 1'b0);
    measure("B", 1, 98, 32, 14, 14, 1'b0);
    measure("C", 2, 189, 15, 9, 14, 1'b1);

    // Random reset pulses; the per-clk model tracks every restart.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (!rst_n) rst_n = ($urandom_range(0, 1) == 0);
      else        rst_n = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "timeout");
  end

endmodule
